// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared state and occupancy encodings for the elastic stage register
// Revision: 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY     = 2'd0,
    PS_FULL      = 2'd1,
    PS_SKID_FULL = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      PS_FULL:      occ = OCC_ONE;
      PS_SKID_FULL: occ = OCC_TWO;
      default:      occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; synchronous active-low reset
// Revision: 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Elastic valid/ready stage register with flush, optional skid slot
//           and saturating stall counter
// Revision: 1.0
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              drain;

  assign out_valid = (state_q != PS_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  if (SKID != 0) begin : g_skid_ready
    // Registered ready: deasserted exactly while the skid slot is occupied.
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (!reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != PS_SKID_FULL);
      end
    end
    assign in_ready = reset & in_ready_q;
  end else begin : g_comb_ready
    assign in_ready = reset & (~out_valid | out_ready);
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          state_d     = PS_FULL;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      PS_FULL: begin
        if (accept && drain) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept && (SKID != 0)) begin
          state_d     = PS_SKID_FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (drain) begin
          state_d = PS_EMPTY;
        end
      end
      PS_SKID_FULL: begin
        if (out_ready) begin
          state_d     = PS_FULL;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    if (flush) begin
      state_d     = PS_EMPTY;
      skid_ctrl_d = '0;
    end
    // An empty stage must never expose live control bits.
    if (state_d == PS_EMPTY) begin
      main_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= PS_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_of(state_q);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stage_reg
// Brief   : Self-checking bench for a skid (A) and a no-skid (B) instance
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW   = 32;
  localparam int CW   = 3;
  localparam int NW   = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [CW-1:0] a_out_ctrl, b_out_ctrl;
  logic [DW-1:0] a_out_data, b_out_data;
  logic [1:0]    a_occ, b_occ;
  logic [NW-1:0] a_stall, b_stall;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall));

  int checks = 0;
  int failures = 0;

  // Reference model: each stage is a FIFO of {ctrl,data} with capacity 2 (A) or 1 (B).
  logic [CW+DW-1:0] qa[$];
  logic [CW+DW-1:0] qb[$];
  int  sa = 0;
  int  sb = 0;
  bit  model_live = 1'b0;

  typedef struct {
    bit            iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit            ordy;
    bit            fl;
    bit            ov;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occ;
    bit            ir;
    logic [NW-1:0] st;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic sample();
    @(negedge clk);
    if (model_live) begin
      chk("A.in_ready", 32'(a_in_ready), 32'(reset && (qa.size() < 2)));
      chk("A.out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
      chk("A.out_ctrl", 32'(a_out_ctrl), (qa.size() > 0) ? 32'(qa[0][CW+DW-1:DW]) : 32'd0);
      if (qa.size() > 0) chk("A.out_data", a_out_data, qa[0][DW-1:0]);
      chk("A.occupancy", 32'(a_occ), 32'(qa.size()));
      chk("A.stall_cnt", 32'(a_stall), 32'(sa));
      chk("B.in_ready", 32'(b_in_ready), 32'(reset && ((qb.size() == 0) || out_ready)));
      chk("B.out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
      chk("B.out_ctrl", 32'(b_out_ctrl), (qb.size() > 0) ? 32'(qb[0][CW+DW-1:DW]) : 32'd0);
      if (qb.size() > 0) chk("B.out_data", b_out_data, qb[0][DW-1:0]);
      chk("B.occupancy", 32'(b_occ), 32'(qb.size()));
      chk("B.stall_cnt", 32'(b_stall), 32'(sb));
    end
  endtask

  task automatic tick();
    bit ira, irb, ova, ovb;
    @(posedge clk);
    ira = reset && (qa.size() < 2);
    irb = reset && ((qb.size() == 0) || out_ready);
    ova = qa.size() > 0;
    ovb = qb.size() > 0;
    if (!reset) begin
      qa.delete();
      qb.delete();
      sa = 0;
      sb = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (ova && !out_ready && sa < SMAX) sa++;
      if (ovb && !out_ready && sb < SMAX) sb++;
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (ova && out_ready) void'(qa.pop_front());
        if (ovb && out_ready) void'(qb.pop_front());
        if (in_valid && ira) qa.push_back({in_ctrl, in_data});
        if (in_valid && irb) qb.push_back({in_ctrl, in_data});
      end
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int delivered;
    //           iv  d      c  ordy fl | ov  od     oc occ ir st
    tbl[0]  = '{1, 32'h11, 5, 1, 0,   0, 32'h0,  0, 0, 1, 0};
    tbl[1]  = '{1, 32'h22, 5, 1, 0,   1, 32'h11, 5, 1, 1, 0};
    tbl[2]  = '{1, 32'h33, 5, 1, 0,   1, 32'h22, 5, 1, 1, 0};
    tbl[3]  = '{0, 32'h0,  0, 1, 0,   1, 32'h33, 5, 1, 1, 0};
    tbl[4]  = '{1, 32'hA,  2, 0, 0,   0, 32'h0,  0, 0, 1, 0};
    tbl[5]  = '{1, 32'hB,  3, 0, 0,   1, 32'hA,  2, 1, 1, 0};
    tbl[6]  = '{0, 32'h0,  0, 0, 0,   1, 32'hA,  2, 2, 0, 1};
    tbl[7]  = '{0, 32'h0,  0, 1, 0,   1, 32'hA,  2, 2, 0, 2};
    tbl[8]  = '{0, 32'h0,  0, 1, 0,   1, 32'hB,  3, 1, 1, 2};
    tbl[9]  = '{0, 32'h0,  0, 1, 0,   0, 32'h0,  0, 0, 1, 2};
    tbl[10] = '{1, 32'h1,  7, 0, 0,   0, 32'h0,  0, 0, 1, 2};
    tbl[11] = '{1, 32'h2,  7, 0, 0,   1, 32'h1,  7, 1, 1, 2};
    tbl[12] = '{1, 32'hC,  7, 0, 1,   1, 32'h1,  7, 2, 0, 3};
    tbl[13] = '{0, 32'h0,  0, 1, 0,   0, 32'h0,  0, 0, 1, 4};
    tbl[14] = '{1, 32'h5,  1, 0, 0,   0, 32'h0,  0, 0, 1, 4};
    tbl[15] = '{1, 32'hD,  1, 0, 1,   1, 32'h5,  1, 1, 1, 4};
    tbl[16] = '{0, 32'h0,  0, 1, 0,   0, 32'h0,  0, 0, 1, 5};

    // Reset held two cycles with a beat offered.
    reset = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 3'b111, 1'b0, 1'b0);
    tick();
    sample();
    chk("rst.out_valid", 32'(a_out_valid), 32'd0);
    chk("rst.out_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("rst.out_data", a_out_data, 32'd0);
    chk("rst.occupancy", 32'(a_occ), 32'd0);
    chk("rst.stall_cnt", 32'(a_stall), 32'd0);
    chk("rst.in_ready_a", 32'(a_in_ready), 32'd0);
    chk("rst.in_ready_b", 32'(b_in_ready), 32'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    sample();
    chk("rst_rel.in_ready_a", 32'(a_in_ready), 32'd1);
    tick();

    // Streaming, skid capture and flush corner cases.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl);
      sample();
      chk($sformatf("T%0d.in_ready", i), 32'(a_in_ready), 32'(tbl[i].ir));
      chk($sformatf("T%0d.out_valid", i), 32'(a_out_valid), 32'(tbl[i].ov));
      chk($sformatf("T%0d.out_ctrl", i), 32'(a_out_ctrl), 32'(tbl[i].oc));
      if (tbl[i].ov) chk($sformatf("T%0d.out_data", i), a_out_data, tbl[i].od);
      chk($sformatf("T%0d.occupancy", i), 32'(a_occ), 32'(tbl[i].occ));
      chk($sformatf("T%0d.stall_cnt", i), 32'(a_stall), 32'(tbl[i].st));
      tick();
    end

    // Stall saturation, flush keeps the count, reset clears it.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h77, 3'b001, 1'b0, 1'b0);
    sample();
    tick();
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    repeat (20) begin
      sample();
      tick();
    end
    sample();
    chk("sat.stall_cnt", 32'(a_stall), 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sample();
    chk("sat.after_flush", 32'(a_stall), 32'd15);
    chk("sat.flush_empty", 32'(a_occ), 32'd0);
    reset = 1'b0;
    tick();
    sample();
    chk("sat.after_reset", 32'(a_stall), 32'd0);
    reset = 1'b1;
    tick();

    // No-skid instance: full-and-stalled blocks input, then full throughput.
    drive(1'b1, 32'h100, 3'b010, 1'b0, 1'b0);
    sample();
    tick();
    sample();
    chk("B.full_stalled_ready", 32'(b_in_ready), 32'd0);
    tick();
    delivered = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h101 + 32'(i), 3'b010, 1'b1, 1'b0);
      sample();
      chk($sformatf("B.stream%0d.occupancy", i), 32'(b_occ), 32'd1);
      if (b_out_valid && out_ready) delivered++;
      tick();
    end
    chk("B.delivered", 32'(delivered), 32'd4);

    // Randomized traffic against the FIFO model.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = $urandom;
      in_ctrl   = CW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      sample();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register for the inter-stage boundaries of the 5-stage RISC-V core. It generalises the fixed stage registers to configurable data and control widths, and adds a valid/ready handshake, flush-to-bubble, an optional skid slot and a saturating stall counter. A bubble always presents zeroed control bits, so a killed instruction can never write architectural state.

Parameters:
DATA_W, 32, width of the payload bundle (ALU result, read data, PC values, rd, ...), concatenated by the instantiator
CTRL_W, 3, width of the control bundle (RegWrite, ResultSrc, ...); forced to zero whenever the stage holds no valid entry
SKID, 1, 1 = two-entry stage (main + skid) with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
flush  in  1  kill all held entries plus any beat accepted this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents a valid beat
out_ready  in  1  downstream accepts the beat
out_ctrl  out  CTRL_W  control of the head entry; 0 when out_valid=0
out_data  out  DATA_W  payload of the head entry
occupancy  out  2  entries held: 0, 1 or 2 (2 only when SKID=1)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- One clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset (reset=0 at an edge): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, skid entry invalid. in_ready is forced to 0 combinationally while reset=0. Reset overrides flush and handshakes.
- Handshake: a beat transfers in when in_valid & in_ready; a beat transfers out when out_valid & out_ready. Outputs change only on clock edges. Latency from accept to out_valid is 1 cycle.
- Order of precedence at an edge: reset > flush > handshake.
- FSM (SKID=1), states EMPTY, FULL, SKID_FULL:
  - EMPTY: in_ready=1. Accept -> FULL (load main).
  - FULL: in_ready=1. Accept & out_ready -> FULL (main <= input). Accept & !out_ready -> SKID_FULL (skid <= input). No accept & out_ready -> EMPTY. Otherwise hold.
  - SKID_FULL: in_ready=0 (registered, = !skid_valid). out_ready -> FULL (main <= skid). Otherwise hold.
- SKID=0: states EMPTY and FULL only. in_ready = !out_valid | out_ready (combinational). A simultaneous accept and drain replaces main, giving throughput of 1 beat per cycle.
- Flush: next state is EMPTY, out_ctrl=0, and the skid entry is invalidated. A beat accepted in the flush cycle is discarded. out_data may hold stale data. stall_cnt is unaffected.
- Ordering: beats leave in acceptance order, with no loss and no duplication.
- out_ctrl is cleared on every transition into EMPTY, not only on flush.
- stall_cnt: +1 on each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by reset.
- occupancy: EMPTY=0, FULL=1, SKID_FULL=2.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] pipe_state_e {PS_EMPTY, PS_FULL, PS_SKID_FULL};
  - occupancy encoding constants.
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count), used for stall_cnt.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=0. Release reset -> in_ready=1 in the next cycle.
2. Streaming (SKID=1, DATA_W=32, CTRL_W=3): out_ready=1; push data 0x11/0x22/0x33 with ctrl 3'b101 on consecutive cycles -> each appears one cycle later with out_ctrl=3'b101; occupancy stays 1; in_ready stays 1.
3. Skid capture: push 0xA then 0xB back-to-back with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Set out_ready=1 -> 0xA then 0xB on the next two cycles, then out_valid=0 and out_ctrl=0.
4. Flush while SKID_FULL with in_valid=1, in_data=0xC in the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xC never appears on out_data.
5. Stall saturation (CNT_W=4): hold a valid entry with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15; a subsequent flush leaves it at 15; reset returns it to 0.
6. SKID=0 instance: full with out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 for 4 cycles -> 4 beats delivered in 4 cycles, occupancy constant at 1.
